// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq : handshaked multi-cycle ALU for the decode -> writeback path.
//   Single-cycle ops : ADD SUB AND OR NOT XOR SLT SLTU (result 1 cycle after
//                      accept). Unused encodings give res=0, z=1.
//   Iterative ops    : MULU (shift-add, 2*WIDTH product) and, when the
//                      ALU_DIV_EN macro is defined, DIVU (restoring divide).
//                      Both present out_valid WIDTH+1 cycles after accept.
//   Build option     : `define ALU_DIV_EN to include the divider. Without it,
//                      encoding 1001 is handled as an unused op.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE, rst_n high)
//   op_a, op_b, sel      operands and operation code, captured on accept
//   out_valid/out_ready  result handshake (out_valid while in DONE)
//   res, res_hi          result; high product / remainder for MULU / DIVU
//   z, c, v, n           zero, carry/borrow, overflow, negative flags
// ----------------------------------------------------------------------------
module alu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] res_hi,
   output logic             z,
   output logic             c,
   output logic             v,
   output logic             n
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned W2 = 2 * WIDTH;

   localparam logic [3:0] SEL_ADD  = 4'b0000;
   localparam logic [3:0] SEL_SUB  = 4'b0001;
   localparam logic [3:0] SEL_AND  = 4'b0010;
   localparam logic [3:0] SEL_OR   = 4'b0011;
   localparam logic [3:0] SEL_NOT  = 4'b0100;
   localparam logic [3:0] SEL_XOR  = 4'b0101;
   localparam logic [3:0] SEL_SLT  = 4'b0110;
   localparam logic [3:0] SEL_SLTU = 4'b0111;
   localparam logic [3:0] SEL_MULU = 4'b1000;
`ifdef ALU_DIV_EN
   localparam logic [3:0] SEL_DIVU = 4'b1001;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [W2-1:0]     r_acc;
   logic [CW-1:0]     r_cnt;
`ifdef ALU_DIV_EN
   logic              r_div;
`endif
   logic [WIDTH-1:0]  r_res;
   logic [WIDTH-1:0]  r_res_hi;
   logic              r_z;
   logic              r_c;
   logic              r_v;
   logic              r_n;

   logic              w_accept;
   logic              w_iter;
   logic              w_last;

   logic [WIDTH:0]    w_sum;
   logic [WIDTH:0]    w_dif;
   logic [WIDTH-1:0]  w_s_res;
   logic              w_s_c;
   logic              w_s_v;

   logic [WIDTH:0]    w_mul_sum;
   logic [W2-1:0]     w_mul_acc;
   logic [W2-1:0]     w_acc_nxt;
   logic [WIDTH-1:0]  w_b_nxt;

   logic [WIDTH-1:0]  w_f_res;
   logic [WIDTH-1:0]  w_f_hi;
   logic              w_f_z;
   logic              w_f_c;
   logic              w_f_v;
   logic              w_f_n;

   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef ALU_DIV_EN
   assign w_iter = (sel == SEL_MULU) || (sel == SEL_DIVU);
`else
   assign w_iter = (sel == SEL_MULU);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_iter ? S_BUSY : S_DONE;
         S_BUSY: if (w_last)   w_state_nxt = S_DONE;
         S_DONE: if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (rst_n && (r_state == S_IDLE)) in_ready = 1'b1;
      if (r_state == S_DONE) out_valid = 1'b1;
   end

   // Single-cycle results, computed straight from the inputs at accept
   always_comb begin
      w_sum   = {1'b0, op_a} + {1'b0, op_b};
      w_dif   = {1'b0, op_a} - {1'b0, op_b};
      w_s_res = '0;
      w_s_c   = 1'b0;
      w_s_v   = 1'b0;
      case (sel)
         SEL_ADD: begin
            w_s_res = w_sum[WIDTH-1:0];
            w_s_c   = w_sum[WIDTH];
            w_s_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         SEL_SUB: begin
            // Top bit of the widened difference is the unsigned borrow
            w_s_res = w_dif[WIDTH-1:0];
            w_s_c   = w_dif[WIDTH];
            w_s_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_dif[WIDTH-1] != op_a[WIDTH-1]);
         end
         SEL_AND:  w_s_res = op_a & op_b;
         SEL_OR:   w_s_res = op_a | op_b;
         SEL_NOT:  w_s_res = ~op_a;
         SEL_XOR:  w_s_res = op_a ^ op_b;
         SEL_SLT:  w_s_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         SEL_SLTU: w_s_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         default:  w_s_res = '0;
      endcase
   end

   // One shift-add step: add multiplicand into the high half, shift right
   assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + {1'b0, ({WIDTH{r_b[0]}} & r_a)};
   assign w_mul_acc = W2'({w_mul_sum, r_acc[WIDTH-1:0]} >> 1);

`ifdef ALU_DIV_EN
   // One restoring-divide step: r_acc = {remainder, dividend/quotient}
   logic [WIDTH:0]   w_trial;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem;
   logic [W2-1:0]    w_div_acc;

   always_comb begin
      w_trial   = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
      w_ge      = (w_trial >= {1'b0, r_b});
      w_rem     = WIDTH'(w_ge ? (w_trial - {1'b0, r_b}) : w_trial);
      w_div_acc = {w_rem, r_acc[WIDTH-2:0], w_ge};
   end

   assign w_acc_nxt = r_div ? w_div_acc : w_mul_acc;
   assign w_b_nxt   = r_div ? r_b : (r_b >> 1);
`else
   assign w_acc_nxt = w_mul_acc;
   assign w_b_nxt   = r_b >> 1;
`endif

   // Final result/flags taken from the last iteration's accumulator value
   always_comb begin
      w_f_res = w_acc_nxt[WIDTH-1:0];
      w_f_hi  = w_acc_nxt[W2-1:WIDTH];
      w_f_z   = (w_acc_nxt == '0);
      w_f_c   = (w_acc_nxt[W2-1:WIDTH] != '0);
      w_f_v   = (w_acc_nxt[W2-1:WIDTH] != '0);
      w_f_n   = w_acc_nxt[WIDTH-1];
`ifdef ALU_DIV_EN
      if (r_div) begin
         w_f_c = 1'b0;
         if (r_b == '0) begin
            w_f_res = '1;
            w_f_hi  = r_a;
            w_f_z   = 1'b0;
            w_f_v   = 1'b1;
            w_f_n   = 1'b1;
         end else begin
            w_f_z = (w_acc_nxt[WIDTH-1:0] == '0);
            w_f_v = 1'b0;
         end
      end
`endif
   end

   // Operand capture, iteration datapath and registered results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
`ifdef ALU_DIV_EN
         r_div    <= 1'b0;
`endif
         r_res    <= '0;
         r_res_hi <= '0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_n      <= 1'b0;
      end else if (w_accept) begin
         r_a   <= op_a;
         r_b   <= op_b;
         r_cnt <= '0;
`ifdef ALU_DIV_EN
         r_div <= (sel == SEL_DIVU);
         r_acc <= (sel == SEL_DIVU) ? {{WIDTH{1'b0}}, op_a} : '0;
`else
         r_acc <= '0;
`endif
         if (!w_iter) begin
            r_res    <= w_s_res;
            r_res_hi <= '0;
            r_z      <= (w_s_res == '0);
            r_c      <= w_s_c;
            r_v      <= w_s_v;
            r_n      <= w_s_res[WIDTH-1];
         end
      end else if (r_state == S_BUSY) begin
         r_acc <= w_acc_nxt;
         r_b   <= w_b_nxt;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_res    <= w_f_res;
            r_res_hi <= w_f_hi;
            r_z      <= w_f_z;
            r_c      <= w_f_c;
            r_v      <= w_f_v;
            r_n      <= w_f_n;
         end
      end
   end

   assign res    = r_res;
   assign res_hi = r_res_hi;
   assign z      = r_z;
   assign c      = r_c;
   assign v      = r_v;
   assign n      = r_n;

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq : bench for alu_seq (WIDTH=32). A transaction-level model predicts
// handshake timing and results from plain arithmetic; a negedge process
// compares the DUT against it every cycle. Directed cases pin known values.
// ----------------------------------------------------------------------------
module tb_alu_seq;

   localparam int unsigned W = 32;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b1;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] op_a      = '0;
   logic [W-1:0] op_b      = '0;
   logic [3:0]   sel       = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] res;
   logic [W-1:0] res_hi;
   logic         z, c, v, n;

   int n_checks = 0;
   int n_fail   = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .res_hi    (res_hi),
      .z         (z),
      .c         (c),
      .v         (v),
      .n         (n)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z;
      logic         c;
      logic         v;
      logic         n;
   } exp_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_iter(input logic [3:0] s);
`ifdef ALU_DIV_EN
      return (s == 4'd8) || (s == 4'd9);
`else
      return (s == 4'd8);
`endif
   endfunction

   // Reference results from plain integer arithmetic
   function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
      exp_t        e;
      longint      sa, sb, sr;
      logic [63:0] p;
      longint      smax, smin;
      e    = '0;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (64'sd1 <<< (W-1)) - 1;
      smin = -(64'sd1 <<< (W-1));
      case (s)
         4'd0: begin
            p     = 64'(a) + 64'(b);
            e.res = p[W-1:0];
            e.c   = (p >> W) != 0;
            sr    = sa + sb;
            e.v   = (sr > smax) || (sr < smin);
         end
         4'd1: begin
            e.res = a - b;
            e.c   = a < b;
            sr    = sa - sb;
            e.v   = (sr > smax) || (sr < smin);
         end
         4'd2: e.res = a & b;
         4'd3: e.res = a | b;
         4'd4: e.res = ~a;
         4'd5: e.res = a ^ b;
         4'd6: e.res = (sa < sb) ? W'(1) : W'(0);
         4'd7: e.res = (a < b) ? W'(1) : W'(0);
         4'd8: begin
            p     = 64'(a) * 64'(b);
            e.res = p[W-1:0];
            e.hi  = p[2*W-1:W];
            e.c   = e.hi != 0;
            e.v   = e.hi != 0;
         end
`ifdef ALU_DIV_EN
         4'd9: begin
            if (b == 0) begin
               e.res = '1;
               e.hi  = a;
               e.v   = 1'b1;
            end else begin
               e.res = a / b;
               e.hi  = a % b;
            end
         end
`endif
         default: e.res = '0;
      endcase
      if (s == 4'd8) e.z = (p == 0);
      else           e.z = (e.res == 0);
      e.n = e.res[W-1];
      return e;
   endfunction

   // Transaction-level model: idle / computing / holding result
   typedef enum int {M_IDLE, M_BUSY, M_DONE} mph_t;
   mph_t m_ph      = M_IDLE;
   int   m_left    = 0;
   int   m_acc_cnt = 0;
   exp_t m_pend    = '0;
   exp_t m_out     = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph   = M_IDLE;
         m_left = 0;
         m_out  = '0;
      end else begin
         case (m_ph)
            M_IDLE: if (in_valid) begin
               m_pend = ref_op(op_a, op_b, sel);
               m_acc_cnt++;
               if (is_iter(sel)) begin
                  m_left = W;
                  m_ph   = M_BUSY;
               end else begin
                  m_out = m_pend;
                  m_ph  = M_DONE;
               end
            end
            M_BUSY: begin
               m_left--;
               if (m_left == 0) begin
                  m_out = m_pend;
                  m_ph  = M_DONE;
               end
            end
            default: if (out_ready) m_ph = M_IDLE;
         endcase
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("in_ready", 64'(in_ready), 64'(rst_n && (m_ph == M_IDLE)));
      chk("out_valid", 64'(out_valid), 64'(m_ph == M_DONE));
      if ((m_ph == M_DONE) || !rst_n) begin
         chk("res", 64'(res), 64'(m_out.res));
         chk("res_hi", 64'(res_hi), 64'(m_out.hi));
         chk("flags_zcvn", 64'({z, c, v, n}), 64'({m_out.z, m_out.c, m_out.v, m_out.n}));
      end
   end

   bit           stream_on = 1'b0;
   logic [W-1:0] q_got[$];

   always @(negedge clk) begin
      if (stream_on && out_valid && out_ready) q_got.push_back(res);
   end

   function automatic logic [W-1:0] rnd();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   // Issue one op, measure accept-to-out_valid latency, check literal values
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                        input logic [W-1:0] er, input logic [W-1:0] eh, input logic [3:0] ezcvn,
                        input int elat, input bit hold, input string nm);
      int cyc;
      bit seen;
      @(posedge clk); #2;
      op_a = a; op_b = b; sel = s; in_valid = 1'b1; out_ready = !hold;
      @(posedge clk); #2;
      in_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom); sel = 4'($urandom);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && (cyc < 200)) begin
         @(negedge clk);
         cyc++;
         seen = out_valid;
      end
      chk({nm, " latency"}, 64'(cyc), 64'(elat));
      if (seen) begin
         chk({nm, " res"}, 64'(res), 64'(er));
         chk({nm, " res_hi"}, 64'(res_hi), 64'(eh));
         chk({nm, " zcvn"}, 64'({z, c, v, n}), 64'(ezcvn));
         if (hold) begin
            repeat (5) begin
               @(negedge clk);
               chk({nm, " hold res"}, 64'(res), 64'(er));
               chk({nm, " hold res_hi"}, 64'(res_hi), 64'(eh));
               chk({nm, " hold out_valid"}, 64'(out_valid), 64'(1));
               chk({nm, " hold in_ready"}, 64'(in_ready), 64'(0));
            end
            @(posedge clk); #2;
            out_ready = 1'b1;
         end
      end
   endtask

   logic [W-1:0] s_a[4];
   logic [W-1:0] s_b[4];
   logic [W-1:0] s_e[4];

   initial begin
      int k, cyc, base;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset res", 64'(res), 64'(0));
      chk("reset res_hi", 64'(res_hi), 64'(0));
      chk("reset zcvn", 64'({z, c, v, n}), 64'(0));
      chk("reset in_ready", 64'(in_ready), 64'(0));
      chk("reset out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #2;
      rst_n = 1'b1;

      do_op(32'hffff_ffff, 32'h1, 4'd0, 32'h0, 32'h0, 4'b1100, 1, 0, "ADD_wrap");
      do_op(32'h8000_0000, 32'h1, 4'd1, 32'h7fff_ffff, 32'h0, 4'b0010, 1, 0, "SUB_ovf");
      do_op(32'h8000_0000, 32'h1, 4'd6, 32'h1, 32'h0, 4'b0000, 1, 0, "SLT");
      do_op(32'h8000_0000, 32'h1, 4'd7, 32'h0, 32'h0, 4'b1000, 1, 0, "SLTU");
      do_op(32'ha5a5_a5a5, 32'hffff_0000, 4'd5, 32'h5a5a_a5a5, 32'h0, 4'b0000, 1, 0, "XOR");
      do_op(32'hffff_ffff, 32'h2, 4'd8, 32'hffff_fffe, 32'h1, 4'b0111, W + 1, 1, "MULU");
`ifdef ALU_DIV_EN
      do_op(32'd100, 32'd7, 4'd9, 32'd14, 32'd2, 4'b0000, W + 1, 0, "DIVU");
      do_op(32'd100, 32'd0, 4'd9, 32'hffff_ffff, 32'd100, 4'b0011, W + 1, 0, "DIVU_zero");
`else
      do_op(32'd100, 32'd7, 4'd9, 32'h0, 32'h0, 4'b1000, 1, 0, "DIVU_absent");
`endif
      do_op(32'h1234_5678, 32'h1, 4'd15, 32'h0, 32'h0, 4'b1000, 1, 0, "ILLEGAL");
      do_op(32'h0, 32'h1, 4'd1, 32'hffff_ffff, 32'h0, 4'b0101, 1, 0, "SUB_borrow");

      // Abort a MULU with reset partway through its iteration
      @(posedge clk); #2;
      op_a = 32'hdead_beef; op_b = 32'h0000_1234; sel = 4'd8; in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort res", 64'(res), 64'(0));
      chk("abort res_hi", 64'(res_hi), 64'(0));
      chk("abort zcvn", 64'({z, c, v, n}), 64'(0));
      chk("abort out_valid", 64'(out_valid), 64'(0));
      chk("abort in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b1;
      do_op(32'd3, 32'd4, 4'd0, 32'd7, 32'h0, 4'b0000, 1, 0, "ADD_after_reset");

      // Back-to-back ADDs with in_valid and out_ready held high
      s_a[0] = 32'd1;         s_b[0] = 32'd2;         s_e[0] = 32'd3;
      s_a[1] = 32'd10;        s_b[1] = 32'd20;        s_e[1] = 32'd30;
      s_a[2] = 32'hffff_ffff; s_b[2] = 32'hffff_ffff; s_e[2] = 32'hffff_fffe;
      s_a[3] = 32'h7fff_ffff; s_b[3] = 32'h1;         s_e[3] = 32'h8000_0000;
      @(posedge clk); #2;
      stream_on = 1'b1;
      base = m_acc_cnt;
      k    = 0;
      cyc  = 0;
      op_a = s_a[0]; op_b = s_b[0]; sel = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
      while ((k < 4) && (cyc < 40)) begin
         @(posedge clk); #2;
         cyc++;
         if ((m_acc_cnt - base) > k) begin
            k = m_acc_cnt - base;
            if (k < 4) begin
               op_a = s_a[k]; op_b = s_b[k];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk("stream accept cycles", 64'(cyc), 64'(7));
      repeat (3) @(negedge clk);
      stream_on = 1'b0;
      chk("stream count", 64'(q_got.size()), 64'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < q_got.size()) chk("stream res", 64'(q_got[i]), 64'(s_e[i]));
      end

      // Randomized traffic with occasional reset pulses
      repeat (3000) begin
         @(posedge clk); #2;
         rst_n     = ($urandom_range(0, 499) != 0);
         in_valid  = $urandom_range(0, 1) != 0;
         op_a      = rnd();
         op_b      = rnd();
         sel       = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #2;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (40) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
